prog_loader: RTL and testbench

Hardware program loader that streams instruction words into the CPU's instruction memory over the `initialize` / `instruction_initialize_*` bus, holding the CPU in reset while loading and releasing it afterwards. It sits between a word source (UART, debug port or bench driver) and the `cpu` top, and replaces hand-sequenced initialisation. Word width, program depth, address stride and per-word bus hold time are parametrised. It also supports reload of a running CPU and overflow detection.

---
 rtl/prog_loader.sv | 216 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Streams instruction words from a word source into the CPU instruction memory
// over the initialize / instruction_initialize_* bus. The CPU is held in reset
// while a program loads. It is released when the word flagged wr_last has been
// written. A start pulse while the CPU runs reloads it.
//
// Optional feature (compile-time macro LOADER_CKSUM_EN):
//   The loader keeps a wrapping DATA_W-bit additive checksum of the accepted
//   words and compares it with cksum_in after the last word. A mismatch keeps
//   the CPU in reset and raises error. Without the macro, cksum_in is ignored
//   and no checksum logic is built.
//
// Parameters:
//   DATA_W       instruction word width
//   ADDR_W       instruction address width
//   DEPTH        maximum words per program (>= 1)
//   ADDR_STRIDE  byte increment between consecutive words
//   HOLD_CYCLES  cycles wr_ready stays low after each accepted word (>= 1)
//
// Ports:
//   clk                             clock, rising edge
//   rst                             asynchronous active-low reset
//   start                           one-cycle pulse, begins a load session
//   base_addr                       address of the first word, sampled on start
//   wr_valid / wr_ready             word handshake with the source
//   wr_data                         instruction word
//   wr_last                         marks the final word of the program
//   cksum_in                        expected checksum (LOADER_CKSUM_EN only)
//   initialize                      high while CPU memory is writable
//   instruction_initialize_data     word to CPU memory
//   instruction_initialize_address  address to CPU memory
//   cpu_rst                         active-high reset to the CPU
//   busy                            session in progress
//   done                            program loaded, CPU released
//   error                           session failed, CPU held
//   word_count                      words written this session
// -----------------------------------------------------------------------------
module prog_loader #(
   parameter  int DATA_W      = 32,
   parameter  int ADDR_W      = 32,
   parameter  int DEPTH       = 16,
   parameter  int ADDR_STRIDE = 4,
   parameter  int HOLD_CYCLES = 2,
   localparam int CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   input  logic [DATA_W-1:0] cksum_in,
   output logic              initialize,
   output logic [DATA_W-1:0] instruction_initialize_data,
   output logic [ADDR_W-1:0] instruction_initialize_address,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  word_count
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_RELEASE,
      S_RUN
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  word_count_q;
   logic [HOLD_W-1:0] hold_q;
   logic              last_q;
   logic              wr_ready_q;
   logic              initialize_q;
   logic              cpu_rst_q;
   logic              busy_q;
   logic              done_q;
   logic              error_q;
   logic [DATA_W-1:0] data_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;

`ifdef LOADER_CKSUM_EN
   logic [DATA_W-1:0] cksum_q;
   logic [DATA_W-1:0] cksum_d;

   // Wrapping sum including the word being accepted this cycle.
   always_comb cksum_d = cksum_q + wr_data;
`else
   logic unused_cksum;

   assign unused_cksum = ^cksum_in;
`endif

   // Address of the word being accepted. The product and the sum wrap modulo
   // 2^ADDR_W, so a base near the top of memory wraps to zero.
   always_comb addr_d = base_q + (ADDR_W'(word_count_q) * ADDR_W'(ADDR_STRIDE));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         base_q       <= '0;
         word_count_q <= '0;
         hold_q       <= '0;
         last_q       <= 1'b0;
         wr_ready_q   <= 1'b0;
         initialize_q <= 1'b1;
         cpu_rst_q    <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         data_q       <= '0;
         addr_q       <= '0;
`ifdef LOADER_CKSUM_EN
         cksum_q      <= '0;
`endif
      end else begin
         case (state_q)
            // A fresh load and a reload of a running CPU both start here.
            // A reload puts the CPU back into reset on the start edge itself.
            S_IDLE, S_RUN: begin
               if (start) begin
                  base_q       <= base_addr;
                  word_count_q <= '0;
                  error_q      <= 1'b0;
                  done_q       <= 1'b0;
                  initialize_q <= 1'b1;
                  cpu_rst_q    <= 1'b1;
                  busy_q       <= 1'b1;
                  wr_ready_q   <= 1'b1;
`ifdef LOADER_CKSUM_EN
                  cksum_q      <= '0;
`endif
                  state_q      <= S_LOAD;
               end
            end

            S_LOAD: begin
               if (wr_valid && wr_ready_q) begin
                  data_q       <= wr_data;
                  addr_q       <= addr_d;
                  word_count_q <= word_count_q + CNT_W'(1);
                  last_q       <= wr_last;
                  hold_q       <= HOLD_W'(HOLD_CYCLES - 1);
                  wr_ready_q   <= 1'b0;
`ifdef LOADER_CKSUM_EN
                  cksum_q      <= cksum_d;
`endif
                  state_q      <= S_HOLD;
               end
            end

            // Keep the word on the bus for HOLD_CYCLES cycles, then decide.
            S_HOLD: begin
               if (hold_q != '0) begin
                  hold_q <= hold_q - HOLD_W'(1);
               end else if (last_q) begin
`ifdef LOADER_CKSUM_EN
                  if (cksum_q == cksum_in) begin
                     state_q <= S_RELEASE;
                  end else begin
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
`else
                  state_q <= S_RELEASE;
`endif
               end else if (word_count_q == CNT_W'(DEPTH)) begin
                  // Program filled the memory without a last marker.
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  wr_ready_q <= 1'b1;
                  state_q    <= S_LOAD;
               end
            end

            // initialize and cpu_rst drop on the same edge, so the CPU never
            // runs while its memory is still writable.
            S_RELEASE: begin
               initialize_q <= 1'b0;
               cpu_rst_q    <= 1'b0;
               done_q       <= 1'b1;
               busy_q       <= 1'b0;
               state_q      <= S_RUN;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign wr_ready                       = wr_ready_q;
   assign initialize                     = initialize_q;
   assign instruction_initialize_data    = data_q;
   assign instruction_initialize_address = addr_q;
   assign cpu_rst                        = cpu_rst_q;
   assign busy                           = busy_q;
   assign done                           = done_q;
   assign error                          = error_q;
   assign word_count                     = word_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Bench for prog_loader. It sends programs with random words and random
// source gaps. Expected bus contents, handshake timing, release timing and
// error outcomes come from the loader's rules, evaluated on a plain list of
// words.
// -----------------------------------------------------------------------------
module tb_prog_loader;

   localparam int DATA_W      = 32;
   localparam int ADDR_W      = 32;
   localparam int DEPTH       = 16;
   localparam int ADDR_STRIDE = 4;
   localparam int HOLD_CYCLES = 2;
   localparam int CNT_W       = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              wr_last;
   logic [DATA_W-1:0] cksum_in;
   logic              initialize;
   logic [DATA_W-1:0] instruction_initialize_data;
   logic [ADDR_W-1:0] instruction_initialize_address;
   logic              cpu_rst;
   logic              busy;
   logic              done;
   logic              error;
   logic [CNT_W-1:0]  word_count;

   always #5 clk = ~clk;

   prog_loader #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .DEPTH      (DEPTH),
      .ADDR_STRIDE(ADDR_STRIDE),
      .HOLD_CYCLES(HOLD_CYCLES)
   ) dut (
      .clk                           (clk),
      .rst                           (rst),
      .start                         (start),
      .base_addr                     (base_addr),
      .wr_valid                      (wr_valid),
      .wr_ready                      (wr_ready),
      .wr_data                       (wr_data),
      .wr_last                       (wr_last),
      .cksum_in                      (cksum_in),
      .initialize                    (initialize),
      .instruction_initialize_data   (instruction_initialize_data),
      .instruction_initialize_address(instruction_initialize_address),
      .cpu_rst                       (cpu_rst),
      .busy                          (busy),
      .done                          (done),
      .error                         (error),
      .word_count                    (word_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: what the memory bus must currently show.
   logic [DATA_W-1:0] exp_data = '0;
   logic [ADDR_W-1:0] exp_addr = '0;
   logic [ADDR_W-1:0] sess_base;
   logic [DATA_W-1:0] sess_words[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {initialize, cpu_rst, wr_ready, busy, done, error}
   function automatic logic [5:0] flags();
      return {initialize, cpu_rst, wr_ready, busy, done, error};
   endfunction

   function automatic logic [DATA_W-1:0] word_sum(input int n);
      logic [DATA_W-1:0] s = '0;
      for (int i = 0; i < n; i++) s += sess_words[i];
      return s;
   endfunction

   function automatic void fill_random(input int n);
      sess_words.delete();
      for (int i = 0; i < n; i++) sess_words.push_back($urandom);
   endfunction

   task automatic start_session(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] ck,
                                input string name);
      sess_base = base;
      base_addr = base;
      cksum_in  = ck;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      base_addr = $urandom;
      checks++;
      if (flags() !== 6'b111100) begin
         errors++;
         $display("FAIL %s_start: flags=%b expected %b", name, flags(), 6'b111100);
      end
      checks++;
      if (word_count !== '0) begin
         errors++;
         $display("FAIL %s_start_count: got %0d expected 0", name, word_count);
      end
   endtask

   // Sends the first nwords of sess_words and checks every cycle, then
   // checks the end of the session (release, or error with the CPU held).
   task automatic load_words(input int nwords, input bit with_last, input bit gappy,
                             input string name);
      int idx   = 0;
      int since = HOLD_CYCLES;
      int cyc   = 0;
      bit acc;
      bit exp_err;
`ifdef LOADER_CKSUM_EN
      exp_err = !with_last || (word_sum(nwords) !== cksum_in);
`else
      exp_err = !with_last;
`endif
      while (idx < nwords && cyc < 1000) begin
         wr_valid = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
         wr_data  = wr_valid ? sess_words[idx] : $urandom;
         wr_last  = with_last && (idx == nwords - 1);
         if (gappy) begin
            start     = ($urandom_range(0, 7) == 0);
            base_addr = $urandom;
         end
         acc = wr_valid && (since >= HOLD_CYCLES);
         tick();
         cyc++;
         start = 1'b0;
         if (acc) begin
            exp_data = sess_words[idx];
            exp_addr = sess_base + ADDR_W'(idx * ADDR_STRIDE);
            idx++;
            since = 0;
         end else begin
            since++;
         end
         checks++;
         if (instruction_initialize_data !== exp_data || instruction_initialize_address !== exp_addr
             || word_count !== CNT_W'(idx)) begin
            errors++;
            $display("FAIL %s_bus: data=%h addr=%h count=%0d expected data=%h addr=%h count=%0d",
                     name, instruction_initialize_data, instruction_initialize_address, word_count,
                     exp_data, exp_addr, idx);
         end
         checks++;
         if ({wr_ready, busy, initialize, cpu_rst, done, error}
             !== {since >= HOLD_CYCLES, 5'b11100}) begin
            errors++;
            $display("FAIL %s_handshake: ready/busy/init/cpu_rst/done/err=%b expected %b",
                     name, {wr_ready, busy, initialize, cpu_rst, done, error},
                     {since >= HOLD_CYCLES, 5'b11100});
         end
      end
      checks++;
      if (idx < nwords) begin
         errors++;
         $display("FAIL %s_timeout: accepted %0d words expected %0d", name, idx, nwords);
      end
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      for (int s = 1; s <= HOLD_CYCLES + 1; s++) begin
         tick();
         if (s < HOLD_CYCLES || (s == HOLD_CYCLES && !exp_err)) begin
            checks++;
            if (flags() !== 6'b110100) begin
               errors++;
               $display("FAIL %s_hold: flags=%b expected %b", name, flags(), 6'b110100);
            end
         end else if (exp_err) begin
            checks++;
            if (flags() !== 6'b110001) begin
               errors++;
               $display("FAIL %s_error: flags=%b expected %b", name, flags(), 6'b110001);
            end
            break;
         end else begin
            checks++;
            if (flags() !== 6'b000010) begin
               errors++;
               $display("FAIL %s_release: flags=%b expected %b", name, flags(), 6'b000010);
            end
         end
      end
      checks++;
      if (instruction_initialize_data !== exp_data || instruction_initialize_address !== exp_addr
          || word_count !== CNT_W'(nwords)) begin
         errors++;
         $display("FAIL %s_retain: data=%h addr=%h count=%0d expected data=%h addr=%h count=%0d",
                  name, instruction_initialize_data, instruction_initialize_address, word_count,
                  exp_data, exp_addr, nwords);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; base_addr = '0; wr_valid = 1'b0;
      wr_data = '0; wr_last = 1'b0; cksum_in = '0;
      repeat (2) tick();
      checks++;
      if (flags() !== 6'b110000) begin
         errors++;
         $display("FAIL reset_flags: flags=%b expected %b", flags(), 6'b110000);
      end
      checks++;
      if (word_count !== '0 || instruction_initialize_data !== '0
          || instruction_initialize_address !== '0) begin
         errors++;
         $display("FAIL reset_bus: count=%0d data=%h addr=%h expected all zero",
                  word_count, instruction_initialize_data, instruction_initialize_address);
      end
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (flags() !== 6'b110000) begin
         errors++;
         $display("FAIL idle_no_start: flags=%b expected %b", flags(), 6'b110000);
      end
   endtask

   task automatic test_basic();
      sess_words = '{32'h00020820, 32'h20430001, 32'h20430002, 32'h20430003, 32'h20430004};
      start_session('0, word_sum(5), "basic");
      load_words(5, 1'b1, 1'b0, "basic");
   endtask

   task automatic test_reload();
      fill_random(1);
      start_session($urandom, word_sum(1), "reload");
      load_words(1, 1'b1, 1'b0, "reload");
   endtask

   task automatic test_wrap();
      fill_random(2);
      start_session(32'hFFFF_FFFC, word_sum(2), "wrap");
      load_words(2, 1'b1, 1'b1, "wrap");
   endtask

   task automatic test_overflow();
      fill_random(DEPTH);
      start_session($urandom, word_sum(DEPTH), "overflow");
      load_words(DEPTH, 1'b0, 1'b1, "overflow");
      repeat (4) tick();
      checks++;
      if (flags() !== 6'b110001) begin
         errors++;
         $display("FAIL overflow_stays_held: flags=%b expected %b", flags(), 6'b110001);
      end
   endtask

   task automatic test_reset_mid();
      fill_random(5);
      start_session($urandom, word_sum(5), "rstmid");
      wr_valid = 1'b1;
      for (int t = 0; t <= 2 * (HOLD_CYCLES + 1); t++) begin
         wr_data = sess_words[t / (HOLD_CYCLES + 1)];
         tick();
      end
      wr_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      exp_data = '0;
      exp_addr = '0;
      checks++;
      if (flags() !== 6'b110000 || word_count !== '0 || instruction_initialize_data !== '0
          || instruction_initialize_address !== '0) begin
         errors++;
         $display("FAIL rstmid_reset: flags=%b count=%0d data=%h addr=%h expected %b and zeros",
                  flags(), word_count, instruction_initialize_data,
                  instruction_initialize_address, 6'b110000);
      end
      // Start is already high on the first edge after reset release.
      fill_random(3);
      sess_base = $urandom;
      base_addr = sess_base;
      cksum_in  = word_sum(3);
      start     = 1'b1;
      #1;
      rst = 1'b1;
      tick();
      start     = 1'b0;
      base_addr = $urandom;
      checks++;
      if (flags() !== 6'b111100) begin
         errors++;
         $display("FAIL rstmid_start_honoured: flags=%b expected %b", flags(), 6'b111100);
      end
      load_words(3, 1'b1, 1'b1, "rstmid");
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         int n = $urandom_range(1, DEPTH);
         fill_random(n);
         start_session($urandom, word_sum(n), "random");
         load_words(n, 1'b1, 1'b1, "random");
      end
   endtask

   task automatic test_cksum();
      sess_words = '{32'd1, 32'd2, 32'd3};
      start_session($urandom, 32'd6, "cksum_ok");
      load_words(3, 1'b1, 1'b0, "cksum_ok");
      start_session($urandom, 32'd7, "cksum_bad");
      load_words(3, 1'b1, 1'b0, "cksum_bad");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reload();
      test_wrap();
      test_overflow();
      test_reload();
      test_reset_mid();
      test_random();
      test_cksum();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
